axi4lite_sensor_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file, the next generation of the fixed four-register read/write slave. It provides NUM_RW software-writable control registers, NUM_CH read-only sensor sample registers with sticky new-sample flags, byte-strobe writes, and SLVERR responses for illegal accesses. It sits between the processor AXI interconnect and the reliability-sensor front ends.

---
 rtl/axi4lite_sensor_regfile.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi4lite_sensor_regfile.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_sensor_regfile.sv
// axi4lite_sensor_regfile
//   AXI4-Lite slave holding NUM_RW software-writable control registers,
//   NUM_CH read-only sensor sample registers and one status word whose bit k
//   flags an unread sample on channel k.
//
//   Word map (index = byte address >> log2(DW/8)):
//     0 .. NUM_RW-1                 control registers, byte-strobe writes
//     NUM_RW .. NUM_RW+NUM_CH-1     sensor samples (read-only)
//     NUM_RW+NUM_CH                 status (read-only, bit k = channel k unread)
//     above                         unmapped -> SLVERR, read data 0
//
//   Ports
//     S_AXI_ACLK, S_AXI_ARESETN     clock, synchronous active-low reset
//     S_AXI_AW*, S_AXI_W*, S_AXI_B* write address / data / response channels
//     S_AXI_AR*, S_AXI_R*           read address / data channels
//     sensor_data, sensor_valid     per-channel sample and one-cycle capture strobe
//     ctrl_out                      flat view of all control registers
//     dbg_w_state, dbg_r_state      1 while the write / read FSM holds a response
//
//   Handshake rule for every channel: a transfer happens on a rising edge
//   where both VALID and READY are 1. The slave never lowers a VALID before
//   its transfer, never changes RDATA/RRESP/BRESP while VALID is held, and
//   every READY/VALID it drives comes straight from a flop.
module axi4lite_sensor_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_RW             = 4,
    parameter int NUM_CH             = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    input  logic [NUM_CH*C_S_AXI_DATA_WIDTH-1:0]   sensor_data,
    input  logic [NUM_CH-1:0]                      sensor_valid,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
    output logic                                   dbg_w_state,
    output logic                                   dbg_r_state
);
    localparam int DW         = C_S_AXI_DATA_WIDTH;
    localparam int AW         = C_S_AXI_ADDR_WIDTH;
    localparam int SW         = DW / 8;
    localparam int ADDR_LSB   = $clog2(SW);
    localparam int STATUS_IDX = NUM_RW + NUM_CH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [DW-1:0]     ctrl_q   [NUM_RW];
    logic [DW-1:0]     sample_q [NUM_CH];
    logic [NUM_CH-1:0] status_q;

    // AW and W are captured independently; whichever arrives first waits here.
    logic          aw_held, w_held;
    logic [AW-1:0] awaddr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;

    logic          aw_hs, w_hs, wr_fire;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [31:0]   wr_idx;

    logic              ar_hs;
    logic [31:0]       rd_idx;
    logic [DW-1:0]     rd_data;
    logic [1:0]        rd_resp;
    logic [NUM_CH-1:0] rd_clear;

    // Protection bits carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign dbg_w_state = (w_state == W_RESP);
    assign dbg_r_state = (r_state == R_DATA);

    // Write path: a channel arriving this cycle bypasses its holding register
    // so AW and W together complete in a single edge.
    always_comb begin
        aw_hs   = S_AXI_AWREADY && S_AXI_AWVALID;
        w_hs    = S_AXI_WREADY && S_AXI_WVALID;
        wr_fire = (aw_held || aw_hs) && (w_held || w_hs);
        wr_addr = aw_held ? awaddr_q : S_AXI_AWADDR;
        wr_data = w_held ? wdata_q : S_AXI_WDATA;
        wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
        wr_idx  = 32'(wr_addr >> ADDR_LSB);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            for (int i = 0; i < NUM_RW; i++) ctrl_q[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= S_AXI_AWADDR;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                    end
                    if (wr_fire) begin
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                        w_state       <= W_RESP;
                        if (wr_idx < NUM_RW) begin
                            S_AXI_BRESP <= RESP_OKAY;
                            for (int i = 0; i < NUM_RW; i++) begin
                                if (wr_idx == i) begin
                                    for (int b = 0; b < SW; b++) begin
                                        if (wr_strb[b]) ctrl_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                                    end
                                end
                            end
                        end else begin
                            // Sensor, status and unmapped words are never written.
                            S_AXI_BRESP <= RESP_SLVERR;
                        end
                    end else begin
                        // Each ready stays up until its own channel has been taken.
                        S_AXI_AWREADY <= !(aw_held || aw_hs);
                        S_AXI_WREADY  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: data is selected from the registers as they stand before
    // this edge, so a same-cycle write or sample capture is not yet visible.
    always_comb begin
        ar_hs    = S_AXI_ARREADY && S_AXI_ARVALID;
        rd_idx   = 32'(S_AXI_ARADDR >> ADDR_LSB);
        rd_data  = '0;
        rd_resp  = RESP_OKAY;
        rd_clear = '0;
        if (rd_idx < NUM_RW) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (rd_idx == i) rd_data = ctrl_q[i];
            end
        end else if (rd_idx < STATUS_IDX) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_idx == NUM_RW + k) rd_data = sample_q[k];
            end
        end else if (rd_idx == STATUS_IDX) begin
            rd_data = DW'(status_q);
        end else begin
            rd_resp = RESP_SLVERR;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            rd_clear[k] = ar_hs && (rd_idx == NUM_RW + k);
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            status_q      <= '0;
            for (int k = 0; k < NUM_CH; k++) sample_q[k] <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= rd_data;
                        S_AXI_RRESP   <= rd_resp;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
            // A fresh sample must never be lost, so the set is written last
            // and overrides a same-cycle clear from a read of that channel.
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_clear[k]) status_q[k] <= 1'b0;
                if (sensor_valid[k]) begin
                    sample_q[k] <= sensor_data[k*DW +: DW];
                    status_q[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < NUM_RW; i++) ctrl_out[i*DW +: DW] = ctrl_q[i];
    end

endmodule

// File: tb/tb_axi4lite_sensor_regfile.sv
// Testbench for axi4lite_sensor_regfile (DW=32, 4 control words, 2 sensor
// channels: control 0x00-0x0C, samples 0x10/0x14, status 0x18, rest unmapped).
// A transaction-level model of the register map predicts every response; a
// negedge compare process checks the DUT against it each cycle, and directed
// sequences pin the model with hand-computed literals.
module tb_axi4lite_sensor_regfile;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NRW = 4;
    localparam int NCH = 2;
    localparam int SW  = DW / 8;
    localparam int W   = DW + 2;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]      awaddr = '0;
    logic               awvalid = 1'b0, awready;
    logic [DW-1:0]      wdata = '0;
    logic [SW-1:0]      wstrb = '0;
    logic               wvalid = 1'b0, wready;
    logic [1:0]         bresp;
    logic               bvalid, bready = 1'b0;
    logic [AW-1:0]      araddr = '0;
    logic               arvalid = 1'b0, arready;
    logic [DW-1:0]      rdata;
    logic [1:0]         rresp;
    logic               rvalid, rready = 1'b0;
    logic [NCH*DW-1:0]  sensor_data = '0;
    logic [NCH-1:0]     sensor_valid = '0;
    logic [NRW*DW-1:0]  ctrl_out;
    logic               dbg_w_state, dbg_r_state;

    axi4lite_sensor_regfile #(
        .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_CH(NCH)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b010), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .sensor_data(sensor_data), .sensor_valid(sensor_valid), .ctrl_out(ctrl_out),
        .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no handshake within bound, expected handshake (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0]  m_ctrl   [NRW];
    logic [DW-1:0]  m_sample [NCH];
    logic [NCH-1:0] m_status;
    logic [W-1:0]   exp_q[$];     // pending read responses {rresp, rdata}
    logic [1:0]     exp_b[$];     // pending write responses
    bit             m_live = 0, m_warm = 0, m_aw_got = 0, m_w_got = 0;
    logic [AW-1:0]  m_awaddr;
    logic [DW-1:0]  m_wdata;
    logic [SW-1:0]  m_wstrb;

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] addr);
        int idx;
        idx = int'(addr) / SW;
        if (idx < NRW)       return {2'b00, m_ctrl[idx]};
        if (idx < NRW + NCH) return {2'b00, m_sample[idx - NRW]};
        if (idx == NRW + NCH) return {2'b00, DW'(m_status)};
        return {2'b10, {DW{1'b0}}};
    endfunction

    // Advances the model on each edge from the handshakes visible at that edge.
    // Reads are resolved first so they see the pre-edge register contents.
    always @(posedge clk) begin : model_step
        int  ridx, widx;
        bit  rd_now;
        if (!resetn) begin
            for (int i = 0; i < NRW; i++) m_ctrl[i] = '0;
            for (int k = 0; k < NCH; k++) m_sample[k] = '0;
            m_status = '0;
            exp_q.delete();
            exp_b.delete();
            m_aw_got = 0;
            m_w_got  = 0;
            m_warm   = 0;
            m_live   = 1;
        end else if (m_live) begin
            if (bvalid && bready && exp_b.size() > 0) void'(exp_b.pop_front());
            if (rvalid && rready && exp_q.size() > 0) void'(exp_q.pop_front());
            rd_now = arvalid && arready;
            ridx   = int'(araddr) / SW;
            if (rd_now) exp_q.push_back(model_read(araddr));
            if (awvalid && awready) begin m_aw_got = 1; m_awaddr = awaddr; end
            if (wvalid && wready) begin m_w_got = 1; m_wdata = wdata; m_wstrb = wstrb; end
            if (m_aw_got && m_w_got) begin
                widx = int'(m_awaddr) / SW;
                if (widx < NRW) begin
                    for (int b = 0; b < SW; b++)
                        if (m_wstrb[b]) m_ctrl[widx][8*b +: 8] = m_wdata[8*b +: 8];
                    exp_b.push_back(2'b00);
                end else begin
                    exp_b.push_back(2'b10);
                end
                m_aw_got = 0;
                m_w_got  = 0;
            end
            if (rd_now && ridx >= NRW && ridx < NRW + NCH) m_status[ridx - NRW] = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (sensor_valid[k]) begin
                    m_sample[k] = sensor_data[k*DW +: DW];
                    m_status[k] = 1'b1;
                end
            end
            m_warm = 1;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("awready", awready, m_warm && exp_b.size() == 0 && !m_aw_got);
            check("wready",  wready,  m_warm && exp_b.size() == 0 && !m_w_got);
            check("arready", arready, m_warm && exp_q.size() == 0);
            check("bvalid",  bvalid,  exp_b.size() > 0);
            check("rvalid",  rvalid,  exp_q.size() > 0);
            if (exp_b.size() > 0) check("bresp", bresp, exp_b[0]);
            if (exp_q.size() > 0) check("rresp_rdata", {rresp, rdata}, exp_q[0]);
            if (!m_warm) check("reset_resp_rdata", {bresp, rresp, rdata}, '0);
            for (int i = 0; i < NRW; i++) check("ctrl_out", ctrl_out[i*DW +: DW], m_ctrl[i]);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered and left just after a rising edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp);
        int t;
        resp = 2'b11;
        fork
            begin
                int ta;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awaddr = addr; awvalid = 1'b1;
                ta = 0;
                do begin @(negedge clk); ta++; end while (!awready && ta < 100);
                if (!awready) timeout("aw_handshake");
                @(posedge clk); #1; awvalid = 1'b0;
            end
            begin
                int tw;
                repeat (w_dly) begin @(posedge clk); #1; end
                wdata = data; wstrb = strb; wvalid = 1'b1;
                tw = 0;
                do begin @(negedge clk); tw++; end while (!wready && tw < 100);
                if (!wready) timeout("w_handshake");
                @(posedge clk); #1; wvalid = 1'b0;
            end
        join
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        if (!bvalid) begin timeout("b_response"); return; end
        resp = bresp;
        repeat (b_dly) @(negedge clk);
        @(posedge clk); #1; bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int pulse_ch,
                           input logic [DW-1:0] pulse_data, input int r_dly,
                           output logic [DW-1:0] data, output logic [1:0] resp);
        int t;
        data = '0;
        resp = 2'b11;
        araddr = addr; arvalid = 1'b1;
        if (pulse_ch >= 0) begin
            sensor_data[pulse_ch*DW +: DW] = pulse_data;
            sensor_valid[pulse_ch] = 1'b1;
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 100);
        if (!arready) timeout("ar_handshake");
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (pulse_ch >= 0) sensor_valid[pulse_ch] = 1'b0;
        t = 0;
        while (!rvalid && t < 100) begin @(negedge clk); t++; end
        if (!rvalid) begin timeout("r_response"); return; end
        data = rdata;
        resp = rresp;
        repeat (r_dly) @(negedge clk);
        @(posedge clk); #1; rready = 1'b1;
        @(posedge clk); #1; rready = 1'b0;
    endtask

    task automatic sensor_pulse(input int ch, input logic [DW-1:0] data);
        sensor_data[ch*DW +: DW] = data;
        sensor_valid[ch] = 1'b1;
        @(posedge clk); #1;
        sensor_valid[ch] = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int idx;
        case ($urandom_range(0, 9))
            7:       idx = 7;
            8:       idx = 16;
            9:       idx = 63;
            default: idx = $urandom_range(0, 6);
        endcase
        return AW'(idx * SW + int'($urandom_range(0, SW - 1)));
    endfunction

    // ---------------- main sequence ----------------
    logic [1:0]    resp;
    logic [DW-1:0] data;

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Basic write then read-back of every control word.
        for (int i = 0; i < NRW; i++) begin
            do_write(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0, 0, resp);
            check("wr_ctrl_bresp", resp, 2'b00);
            check("ctrl_out_after_wr", ctrl_out[i*DW +: DW], DW'(i + 1));
        end
        for (int i = 0; i < NRW; i++) begin
            do_read(AW'(i * 4), -1, '0, 0, data, resp);
            check("rd_ctrl", {resp, data}, {2'b00, DW'(i + 1)});
        end

        // Byte strobes merge old and new bytes.
        do_write(8'h00, 32'hAABBCCDD, 4'hF, 0, 0, 1, resp);
        do_write(8'h00, 32'h11223344, 4'b0101, 0, 0, 0, resp);
        do_read(8'h00, -1, '0, 0, data, resp);
        check("strobe_merge", data, 32'hAA22CC44);
        check("model_strobe_merge", m_ctrl[0], 32'hAA22CC44);

        // W three cycles ahead of AW, response held off for five cycles.
        do_write(8'h04, 32'h5A5A0F0F, 4'hF, 3, 0, 5, resp);
        check("skewed_wr_bresp", resp, 2'b00);
        check("skewed_wr_ctrl_out", ctrl_out[DW +: DW], 32'h5A5A0F0F);

        // Sensor capture, sticky status, clear on sample read.
        sensor_pulse(1, 32'h0000BEEF);
        do_read(8'h18, -1, '0, 0, data, resp);
        check("status_after_pulse", data, 32'h2);
        do_read(8'h14, -1, '0, 2, data, resp);
        check("sample_ch1", {resp, data}, {2'b00, 32'h0000BEEF});
        do_read(8'h18, -1, '0, 0, data, resp);
        check("status_cleared", data, 32'h0);
        // New sample arrives on the same edge as the sample read.
        do_read(8'h14, 1, 32'h00001234, 0, data, resp);
        check("sample_same_cycle_old", data, 32'h0000BEEF);
        do_read(8'h18, -1, '0, 0, data, resp);
        check("status_set_wins", data, 32'h2);
        check("model_status_set_wins", m_status, 2'b10);
        do_read(8'h14, -1, '0, 0, data, resp);
        check("sample_ch1_new", data, 32'h00001234);
        // New sample arrives on the same edge as a status read.
        do_read(8'h18, 0, 32'h00000099, 0, data, resp);
        check("status_same_cycle_old", data, 32'h0);
        do_read(8'h18, -1, '0, 0, data, resp);
        check("status_ch0_set", data, 32'h1);

        // Illegal writes and unmapped reads.
        do_write(8'h10, 32'hFFFFFFFF, 4'hF, 0, 1, 0, resp);
        check("wr_sensor_slverr", resp, 2'b10);
        do_write(8'h40, 32'hFFFFFFFF, 4'hF, 1, 0, 0, resp);
        check("wr_unmapped_slverr", resp, 2'b10);
        do_read(8'h10, -1, '0, 0, data, resp);
        check("sensor_unchanged", {resp, data}, {2'b00, 32'h00000099});
        do_read(8'h40, -1, '0, 0, data, resp);
        check("rd_unmapped", {resp, data}, {2'b10, 32'h0});

        // Reset while a write response is pending.
        awaddr = 8'h08; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        check("bvalid_pending", bvalid, 1'b1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("bvalid_after_reset", bvalid, 1'b0);
        check("ctrl_out_after_reset", ctrl_out, '0);
        check("rdata_after_reset", rdata, '0);
        resetn = 1'b1;
        @(posedge clk); #1;
        do_write(8'h00, 32'h00000077, 4'hF, 0, 0, 0, resp);
        check("wr_after_reset", resp, 2'b00);
        do_read(8'h00, -1, '0, 0, data, resp);
        check("rd_after_reset", data, 32'h77);
        do_read(8'h18, -1, '0, 0, data, resp);
        check("status_after_reset", data, 32'h0);

        // Randomized concurrent traffic on both paths plus sensor strobes.
        fork
            begin
                logic [1:0] r;
                repeat (30) begin
                    do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                logic [1:0]    r;
                logic [DW-1:0] d;
                repeat (30) begin
                    do_read(rand_addr(), -1, '0, $urandom_range(0, 3), d, r);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                repeat (60) begin
                    repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                    sensor_data  = {$urandom, $urandom};
                    sensor_valid = 2'($urandom_range(1, 3));
                    @(posedge clk); #1;
                    sensor_valid = '0;
                end
            end
        join

        repeat (5) begin @(posedge clk); #1; end
        check("read_queue_drained", exp_q.size(), 0);
        check("write_queue_drained", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
